// File: rtl/cache_2way_ctrl_if.sv
// CPU and memory bus bundle for cache_2way_ctrl.
// slave: the cache controller; master: the core and memory side driving it.
interface cache_2way_ctrl_if #(
    parameter int ADDR      = 10,
    parameter int MEM_WIDTH = 32,
    parameter int WORDS     = 4
);
    logic                       cpu_req;
    logic                       cpu_we;
    logic [ADDR-1:0]            cpu_addr;
    logic [MEM_WIDTH-1:0]       cpu_wdata;
    logic [MEM_WIDTH-1:0]       cpu_rdata;
    logic                       cpu_ready;
    logic                       mem_req;
    logic                       mem_we;
    logic [ADDR-1:0]            mem_addr;
    logic [MEM_WIDTH-1:0]       mem_wdata;
    logic [WORDS*MEM_WIDTH-1:0] mem_rblock;
    logic                       mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rblock, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rblock, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative write-through, no-write-allocate cache with miss FSM and LRU.
// Optional hit/miss performance counters when PERF_CNT_EN is defined.
module cache_2way_ctrl #(
    parameter int ADDR      = 10,
    parameter int MEM_WIDTH = 32,
    parameter int WORDS     = 4,
    parameter int SETS      = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    cache_2way_ctrl_if.slave bus
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);
    localparam int OFF = $clog2(WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR - IDX - OFF;

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM} state_t;

    state_t state_q, state_d;

    logic [TAG-1:0]       tag_q   [SETS][2];
    logic [MEM_WIDTH-1:0] data_q  [SETS][2][WORDS];
    logic [1:0]           valid_q [SETS];
    logic [SETS-1:0]      lru_q;

    logic [TAG-1:0] cpu_tag;
    logic [IDX-1:0] cpu_idx;
    logic [OFF-1:0] cpu_off;
    logic           hit_w0, hit_w1, hit, hit_way, victim;

    logic                 fill_en, wr_hit_en, lru_upd, lru_val;
    logic                 mem_req_d, mem_we_d;
    logic [ADDR-1:0]      mem_addr_d;
    logic [MEM_WIDTH-1:0] mem_wdata_d;

    assign cpu_tag = bus.cpu_addr[ADDR-1 -: TAG];
    assign cpu_idx = bus.cpu_addr[OFF +: IDX];
    assign cpu_off = bus.cpu_addr[OFF-1:0];

    assign hit_w0  = valid_q[cpu_idx][0] & (tag_q[cpu_idx][0] == cpu_tag);
    assign hit_w1  = valid_q[cpu_idx][1] & (tag_q[cpu_idx][1] == cpu_tag);
    assign hit     = hit_w0 | hit_w1;
    assign hit_way = hit_w1;
    // Fill empty ways first; only a full set consults LRU.
    assign victim  = ~valid_q[cpu_idx][0] ? 1'b0 :
                     ~valid_q[cpu_idx][1] ? 1'b1 : lru_q[cpu_idx];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        bus.cpu_ready  = 1'b0;
        bus.cpu_rdata  = '0;
        fill_en        = 1'b0;
        wr_hit_en      = 1'b0;
        lru_upd        = 1'b0;
        lru_val        = 1'b0;
        mem_req_d      = bus.mem_req;
        mem_we_d       = bus.mem_we;
        mem_addr_d     = bus.mem_addr;
        mem_wdata_d    = bus.mem_wdata;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req && !bus.cpu_we) begin
                    if (hit) begin
                        bus.cpu_ready = 1'b1;
                        bus.cpu_rdata = data_q[cpu_idx][hit_way][cpu_off];
                        lru_upd       = 1'b1;
                        lru_val       = ~hit_way;
                    end else begin
                        state_d    = RD_MEM;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_tag, cpu_idx, {OFF{1'b0}}};
                    end
                end else if (bus.cpu_req) begin
                    state_d     = WR_MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    wr_hit_en   = hit;
                    lru_upd     = hit;
                    lru_val     = ~hit_way;
                end
            end
            RD_MEM: begin
                if (bus.mem_ack) begin
                    fill_en   = 1'b1;
                    lru_upd   = 1'b1;
                    lru_val   = ~victim;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WR_MEM: begin
                if (bus.mem_ack) begin
                    bus.cpu_ready = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state_q       <= state_d;
            bus.mem_req   <= mem_req_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
            lru_q <= '0;
        end else begin
            if (fill_en) valid_q[cpu_idx][victim] <= 1'b1;
            if (lru_upd) lru_q[cpu_idx] <= lru_val;
        end
    end

    // NOTE: tag/data arrays are deliberately unreset; valid bits qualify every lookup.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[cpu_idx][victim] <= cpu_tag;
            for (int w = 0; w < WORDS; w++)
                data_q[cpu_idx][victim][w] <= bus.mem_rblock[w*MEM_WIDTH +: MEM_WIDTH];
        end else if (wr_hit_en) begin
            data_q[cpu_idx][hit_way][cpu_off] <= bus.cpu_wdata;
        end
    end

`ifdef PERF_CNT_EN
    logic after_fill_q;

    // The lookup right after a refill is the retry of a counted miss.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            after_fill_q <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            after_fill_q <= (state_q == RD_MEM);
            if (state_q == IDLE && bus.cpu_req) begin
                if (!hit)              miss_cnt <= miss_cnt + 1'b1;
                else if (!after_fill_q) hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Directed self-checking bench for cache_2way_ctrl (default parameters).
// Memory block for word address a returns 0xC0DE0000 | a unless overridden.
module tb_cache_2way_ctrl;
    localparam int ADDR = 10;
    localparam int MW   = 32;
    localparam int WDS  = 4;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    cache_2way_ctrl_if #(.ADDR(ADDR), .MEM_WIDTH(MW), .WORDS(WDS)) bus ();

`ifdef PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_2way_ctrl #(.ADDR(ADDR), .MEM_WIDTH(MW), .WORDS(WDS), .SETS(16), .CNT_W(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus)
`ifdef PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WDS*MW-1:0] mk_block(input logic [ADDR-1:0] a);
        logic [WDS*MW-1:0] b;
        for (int i = 0; i < WDS; i++)
            b[i*MW +: MW] = 32'hC0DE_0000 | {22'h0, a[ADDR-1:2], 2'(i)};
        return b;
    endfunction

    // Starts and ends at a negedge with cpu_req low.
    task automatic load(input logic [ADDR-1:0] a, input bit miss,
                        input logic [WDS*MW-1:0] blk, input logic [31:0] exp, input string nm);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        #1;
        if (miss) begin
            check({nm, "_miss_ready"}, 32'(bus.cpu_ready), 32'd0);
            @(negedge clk);
            check({nm, "_mem_req"}, 32'(bus.mem_req), 32'd1);
            check({nm, "_mem_we"}, 32'(bus.mem_we), 32'd0);
            check({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'({a[ADDR-1:2], 2'b00}));
            check({nm, "_wait_ready"}, 32'(bus.cpu_ready), 32'd0);
            bus.mem_rblock = blk;
            bus.mem_ack    = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            check({nm, "_req_drop"}, 32'(bus.mem_req), 32'd0);
        end
        check({nm, "_ready"}, 32'(bus.cpu_ready), 32'd1);
        check({nm, "_rdata"}, bus.cpu_rdata, exp);
        check({nm, "_no_mem"}, 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
    endtask

    task automatic store(input logic [ADDR-1:0] a, input logic [31:0] d, input string nm);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        #1;
        check({nm, "_early_ready"}, 32'(bus.cpu_ready), 32'd0);
        @(negedge clk);
        check({nm, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        check({nm, "_mem_we"}, 32'(bus.mem_we), 32'd1);
        check({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'(a));
        check({nm, "_mem_wdata"}, bus.mem_wdata, d);
        check({nm, "_wait_ready"}, 32'(bus.cpu_ready), 32'd0);
        bus.mem_ack = 1'b1;
        #1;
        check({nm, "_ack_ready"}, 32'(bus.cpu_ready), 32'd1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        #1;
        check({nm, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        logic [WDS*MW-1:0] blk;
        rstn           = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.mem_rblock = '0;
        bus.mem_ack    = 1'b0;
        #2;
        check("rst_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Stray ack in IDLE has no effect
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("idle_ack_ignored", 32'(bus.mem_req), 32'd0);

        // Cold miss then same-block hit
        load(10'h004, 1'b1, mk_block(10'h004), 32'hC0DE_0004, "ld004_cold");
        load(10'h007, 1'b0, '0, 32'hC0DE_0007, "ld007_hit");
`ifdef PERF_CNT_EN
        check("perf_hit_1", 32'(hit_cnt), 32'd1);
        check("perf_miss_1", 32'(miss_cnt), 32'd1);
`endif

        // Fill both ways of set 1, touch 0x004, then 0x084 must evict 0x044
        load(10'h044, 1'b1, mk_block(10'h044), 32'hC0DE_0044, "ld044_fill");
        load(10'h004, 1'b0, '0, 32'hC0DE_0004, "ld004_hit");
        load(10'h086, 1'b1, mk_block(10'h084), 32'hC0DE_0086, "ld086_evict");
        load(10'h004, 1'b0, '0, 32'hC0DE_0004, "ld004_kept");
        load(10'h044, 1'b1, mk_block(10'h044), 32'hC0DE_0044, "ld044_evicted");

        // Write hit updates the line and goes through to memory
        store(10'h005, 32'hDEAD_BEEF, "st005_hit");
        load(10'h005, 1'b0, '0, 32'hDEAD_BEEF, "ld005_new");
        load(10'h006, 1'b0, '0, 32'hC0DE_0006, "ld006_same");

        // Write miss does not allocate
        store(10'h3F0, 32'h1234_5678, "st3f0_miss");
        blk = mk_block(10'h3F0);
        blk[31:0] = 32'h1234_5678;
        load(10'h3F0, 1'b1, blk, 32'h1234_5678, "ld3f0_refill");
`ifdef PERF_CNT_EN
        check("perf_hit_6", 32'(hit_cnt), 32'd6);
        check("perf_miss_6", 32'(miss_cnt), 32'd6);
`endif

        // Reset during RD_MEM abandons the refill and invalidates lines
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h200;
        @(negedge clk);
        check("rdmem_req", 32'(bus.mem_req), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_req", 32'(bus.mem_req), 32'd0);
        check("async_rst_ready", 32'(bus.cpu_ready), 32'd0);
`ifdef PERF_CNT_EN
        check("perf_rst_hit", 32'(hit_cnt), 32'd0);
        check("perf_rst_miss", 32'(miss_cnt), 32'd0);
`endif
        @(negedge clk);
        bus.cpu_req = 1'b0;
        rstn        = 1'b1;
        @(negedge clk);
        load(10'h004, 1'b1, mk_block(10'h004), 32'hC0DE_0004, "ld004_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
